// File: rtl/gated_burst_pkg.sv
// rtl/gated_burst_pkg.sv - shared state and mode encodings for the gated burst controller
package gated_burst_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [1:0] MODE_CONT  = 2'b00;
    localparam logic [1:0] MODE_GATE  = 2'b01;
    localparam logic [1:0] MODE_BURST = 2'b10;
    localparam logic [1:0] MODE_OFF   = 2'b11;

endpackage

// File: rtl/gated_burst_ch.sv
// rtl/gated_burst_ch.sv - one channel: run/stop FSM aligned to waveform-period boundaries
module gated_burst_ch
    import gated_burst_pkg::*;
#(
    parameter int BURST_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         mode,
    input  logic               gate,
    input  logic               trig,
    input  logic [BURST_W-1:0] burst_count,
    input  logic               carry,
    input  logic               abort,
    output logic               run,
    output logic               done,
    output logic               busy
);

    state_t             state;
    logic [1:0]         mode_q;
    logic [BURST_W-1:0] cnt;
    logic               trig_d;
    logic               trig_edge;

    assign trig_edge = trig & ~trig_d;

    // Outputs are assigned alongside every state change so they stay registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            mode_q <= MODE_CONT;
            cnt    <= '0;
            trig_d <= 1'b0;
            run    <= 1'b0;
            done   <= 1'b0;
            busy   <= 1'b0;
        end else begin
            trig_d <= trig;
            done   <= 1'b0;
            if (abort) begin
                state <= ST_IDLE;
                cnt   <= '0;
                run   <= 1'b0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        mode_q <= mode;
                        case (mode)
                            MODE_CONT: begin
                                state <= ST_RUN;
                                run   <= 1'b1;
                                busy  <= 1'b1;
                            end
                            MODE_GATE: if (gate) begin
                                state <= ST_RUN;
                                run   <= 1'b1;
                                busy  <= 1'b1;
                            end
                            MODE_BURST: if (trig_edge) begin
                                state <= ST_RUN;
                                cnt   <= burst_count;
                                run   <= 1'b1;
                                busy  <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    ST_RUN: begin
                        case (mode_q)
                            MODE_CONT: ;
                            MODE_GATE: if (!gate) begin
                                if (carry) begin
                                    state <= ST_IDLE;
                                    run   <= 1'b0;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                end else begin
                                    state <= ST_DRAIN;
                                end
                            end
                            // A zero count means unlimited: never decrements, never ends.
                            MODE_BURST: if (carry && cnt != '0) begin
                                cnt <= cnt - BURST_W'(1);
                                if (cnt == BURST_W'(1)) begin
                                    state <= ST_IDLE;
                                    run   <= 1'b0;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                end
                            end
                            default: begin
                                state <= ST_IDLE;
                                run   <= 1'b0;
                                busy  <= 1'b0;
                            end
                        endcase
                    end
                    ST_DRAIN: begin
                        if (gate) begin
                            state <= ST_RUN;
                        end else if (carry) begin
                            state <= ST_IDLE;
                            run   <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        run   <= 1'b0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/gated_burst_ctrl.sv
// rtl/gated_burst_ctrl.sv - multi-channel run/stop controller for the waveform output path
module gated_burst_ctrl
    import gated_burst_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int BURST_W = 16
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic [2*NUM_CH-1:0]       Mode,
    input  logic [NUM_CH-1:0]         Gate_in,
    input  logic [NUM_CH-1:0]         Trig_in,
    input  logic [NUM_CH*BURST_W-1:0] Burst_count,
    input  logic [NUM_CH-1:0]         Carry_in,
    input  logic [NUM_CH-1:0]         Abort,
    output logic [NUM_CH-1:0]         Run_out,
    output logic [NUM_CH-1:0]         Done_pulse,
    output logic [NUM_CH-1:0]         Busy
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        gated_burst_ch #(
            .BURST_W(BURST_W)
        ) u_ch (
            .clk        (Clock),
            .rst        (Reset),
            .mode       (Mode[2*i +: 2]),
            .gate       (Gate_in[i]),
            .trig       (Trig_in[i]),
            .burst_count(Burst_count[i*BURST_W +: BURST_W]),
            .carry      (Carry_in[i]),
            .abort      (Abort[i]),
            .run        (Run_out[i]),
            .done       (Done_pulse[i]),
            .busy       (Busy[i])
        );
    end

endmodule
